// File: rtl/parallel_serial_interface.sv
// Output stage of the matrix-inversion datapath: captures nine result elements
// on start and streams them as bytes (a..i, high byte first) with valid/ready.
module parallel_serial_interface #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] a_out,
  input  logic [WORD_W-1:0] b_out,
  input  logic [WORD_W-1:0] c_out,
  input  logic [WORD_W-1:0] d_out,
  input  logic [WORD_W-1:0] e_out,
  input  logic [WORD_W-1:0] f_out,
  input  logic [WORD_W-1:0] g_out,
  input  logic [WORD_W-1:0] h_out,
  input  logic [WORD_W-1:0] i_out,
  output logic [7:0]        serial_out,
  output logic              serial_valid,
  input  logic              serial_ready,
  output logic              busy,
  output logic              done
);

  localparam int BPW   = WORD_W / 8;
  localparam int NB    = 9 * BPW;
  localparam int CNT_W = $clog2(NB);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NB*8-1:0]  shadow_q;
  logic [7:0]       byte_sel;
  logic             load;

  assign load = (state_q == IDLE) && start;

  // NOTE: the shadow holds pure data that is always rewritten before it is
  // read, so it has no reset; that keeps it out of the reset tree.
  always_ff @(posedge clk) begin
    if (load) begin
      shadow_q <= {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out, i_out};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (serial_ready) begin
          if (cnt_q == LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte k of the stream sits k bytes below the top of the packed shadow.
  always_comb begin
    byte_sel = '0;
    for (int k = 0; k < NB; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        byte_sel = shadow_q[(NB-1-k)*8 +: 8];
      end
    end
  end

  assign serial_valid = (state_q == SEND);
  assign serial_out   = serial_valid ? byte_sel : 8'h00;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_parallel_serial_interface.sv
// Directed bench for parallel_serial_interface: per-cycle vector tables for the
// streaming cases plus hand-written reset and back-to-back sequences.
module tb_parallel_serial_interface;

  localparam int NB = 18;

  typedef struct {
    logic        start;
    logic        ready;
    logic [15:0] a_val;
    logic        exp_valid;
    logic [7:0]  exp_out;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        serial_ready;
  logic [15:0] words [9];
  logic [7:0]  serial_out;
  logic        serial_valid;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  vec_t       vecs[$];
  logic [7:0] basic_bytes [NB];
  logic [7:0] ffff_bytes  [NB];
  logic [7:0] alt_bytes   [NB];
  int         no_stall    [NB];
  int         bp_stall    [NB];

  always #5 clk = ~clk;

  parallel_serial_interface #(.WORD_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .a_out        (words[0]),
    .b_out        (words[1]),
    .c_out        (words[2]),
    .d_out        (words[3]),
    .e_out        (words[4]),
    .f_out        (words[5]),
    .g_out        (words[6]),
    .h_out        (words[7]),
    .i_out        (words[8]),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .serial_ready (serial_ready),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic st, input logic rdy, input logic [15:0] a,
                         input logic v, input logic [7:0] o, input logic b, input logic d);
    vec_t x;
    x.start = st; x.ready = rdy; x.a_val = a;
    x.exp_valid = v; x.exp_out = o; x.exp_busy = b; x.exp_done = d;
    vecs.push_back(x);
  endtask

  // One SEND cycle per byte plus its stall cycles, then the DONE cycle.
  task automatic add_stream(input logic [7:0] bytes [NB], input int stalls [NB],
                            input logic [15:0] a, input int start_at_byte,
                            input logic start_in_done);
    for (int k = 0; k < NB; k++) begin
      for (int s = 0; s < stalls[k]; s++)
        add_vec(k == start_at_byte, 1'b0, a, 1'b1, bytes[k], 1'b1, 1'b0);
      add_vec(k == start_at_byte, 1'b1, a, 1'b1, bytes[k], 1'b1, 1'b0);
    end
    add_vec(start_in_done, 1'b1, a, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      start        = vecs[i].start;
      serial_ready = vecs[i].ready;
      words[0]     = vecs[i].a_val;
      check($sformatf("%s[%0d] valid", tag, i), 32'(serial_valid), 32'(vecs[i].exp_valid));
      check($sformatf("%s[%0d] out",   tag, i), 32'(serial_out),   32'(vecs[i].exp_out));
      check($sformatf("%s[%0d] busy",  tag, i), 32'(busy),         32'(vecs[i].exp_busy));
      check($sformatf("%s[%0d] done",  tag, i), 32'(done),         32'(vecs[i].exp_done));
      tick();
    end
    vecs.delete();
  endtask

  initial begin
    int valid_cnt, done_cnt, mism;

    basic_bytes = '{8'hAA, 8'h55, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE,
                    8'hF0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    ffff_bytes  = basic_bytes; ffff_bytes[0] = 8'hFF; ffff_bytes[1] = 8'hFF;
    alt_bytes   = basic_bytes; alt_bytes[0]  = 8'h0F; alt_bytes[1]  = 8'h1E;
    for (int k = 0; k < NB; k++) begin
      no_stall[k] = 0;
      bp_stall[k] = (k == 12) ? 3 : (k >= 14) ? 1 : 0;
    end
    words = '{16'hAA55, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
              16'h1122, 16'h3344, 16'h5566, 16'h7788};

    // Reset and idle
    rst = 1'b0; start = 1'b0; serial_ready = 1'b0;
    tick(); tick();
    check("rst valid", 32'(serial_valid), 0);
    check("rst out",   32'(serial_out),   0);
    check("rst busy",  32'(busy),         0);
    check("rst done",  32'(done),         0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      serial_ready = i[0];
      tick();
      check($sformatf("idle ready pulse %0d valid", i), 32'(serial_valid), 0);
      check($sformatf("idle ready pulse %0d busy", i),  32'(busy),         0);
    end

    // Basic stream
    add_vec(1'b1, 1'b1, 16'hAA55, 1'b0, 8'h00, 1'b0, 1'b0);
    add_stream(basic_bytes, no_stall, 16'hAA55, -1, 1'b0);
    add_vec(1'b0, 1'b1, 16'hAA55, 1'b0, 8'h00, 1'b0, 1'b0);
    run_table("basic");

    // Backpressure: 3 stalls on byte 12, one before each of bytes 14..17
    add_vec(1'b1, 1'b1, 16'hAA55, 1'b0, 8'h00, 1'b0, 1'b0);
    add_stream(basic_bytes, bp_stall, 16'hAA55, -1, 1'b0);
    add_vec(1'b0, 1'b1, 16'hAA55, 1'b0, 8'h00, 1'b0, 1'b0);
    run_table("bp");

    // Input isolation, ignored starts in SEND and DONE, new capture in IDLE
    add_vec(1'b1, 1'b1, 16'hAA55, 1'b0, 8'h00, 1'b0, 1'b0);
    add_stream(basic_bytes, no_stall, 16'hFFFF, 5, 1'b1);
    add_vec(1'b1, 1'b1, 16'hFFFF, 1'b0, 8'h00, 1'b0, 1'b0);
    add_stream(ffff_bytes, no_stall, 16'hFFFF, -1, 1'b0);
    add_vec(1'b0, 1'b1, 16'hFFFF, 1'b0, 8'h00, 1'b0, 1'b0);
    run_table("iso");
    words[0] = 16'hAA55;

    // Reset mid-stream after byte 7 is presented
    start = 1'b1; serial_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("midrst byte7", 32'(serial_out), 32'h0000_00BC);
    #2 rst = 1'b0;
    #1;
    check("midrst valid", 32'(serial_valid), 0);
    check("midrst out",   32'(serial_out),   0);
    check("midrst busy",  32'(busy),         0);
    check("midrst done",  32'(done),         0);
    tick();
    check("midrst held busy", 32'(busy), 0);
    rst = 1'b1;
    add_vec(1'b1, 1'b1, 16'h0F1E, 1'b0, 8'h00, 1'b0, 1'b0);
    add_stream(alt_bytes, no_stall, 16'h0F1E, -1, 1'b0);
    add_vec(1'b0, 1'b1, 16'h0F1E, 1'b0, 8'h00, 1'b0, 1'b0);
    run_table("restart");
    words[0] = 16'hAA55;

    // Back-to-back with start held high: period NB+2 = 20 cycles
    valid_cnt = 0; done_cnt = 0; mism = 0;
    start = 1'b1; serial_ready = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (serial_valid) valid_cnt++;
      if (done) done_cnt++;
      if (serial_valid !== (((t-1) % 20) < 18)) mism++;
      if (done !== (((t-1) % 20) == 18)) mism++;
      if (((t-1) % 20) < 18 && serial_out !== basic_bytes[(t-1) % 20]) mism++;
    end
    check("b2b valid cycles", 32'(valid_cnt), 54);
    check("b2b done cycles",  32'(done_cnt),  3);
    check("b2b pattern",      32'(mism),      0);
    start = 1'b0;
    for (int i = 0; i < 21; i++) tick();
    check("b2b drained busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
